// File: rtl/servo_pwm_array.sv
// N-channel servo PWM generator: shared frame counter, per-channel slew-limited
// position tracking and position-to-pulse-width mapping, updated only at frame boundaries.
module servo_pwm_array #(
  parameter int CHANNELS   = 2,
  parameter int IN_W       = 15,
  parameter int PERIOD_CYC = 1000000,
  parameter int MIN_CYC    = 50000,
  parameter int MAX_CYC    = 100000,
  parameter int SLEW       = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS*IN_W-1:0] target,
  input  logic                     target_valid,
  input  logic                     hold,
  input  logic [CHANNELS-1:0]      ch_enable,
  output logic [CHANNELS-1:0]      pwm,
  output logic                     frame_start,
  output logic [CHANNELS*IN_W-1:0] cur,
  output logic [CHANNELS-1:0]      settled
);

  localparam int              CW     = $clog2(PERIOD_CYC + 1);
  localparam logic [CW-1:0]   LAST   = CW'(PERIOD_CYC - 1);
  localparam logic [IN_W-1:0] CENTRE = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] SLEW_N = IN_W'(SLEW);
  localparam logic [63:0]     SLEW_L = 64'(SLEW);
  localparam logic [63:0]     SPAN   = 64'(MAX_CYC - MIN_CYC);

  // The clamped branch is only taken when the gap exceeds SLEW, so c +/- SLEW cannot wrap.
  function automatic logic [IN_W-1:0] slew_step(input logic [IN_W-1:0] c,
                                                input logic [IN_W-1:0] t);
    logic            up;
    logic [IN_W-1:0] diff;
    up   = (t > c);
    diff = up ? (t - c) : (c - t);
    if (SLEW == 0 || 64'(diff) <= SLEW_L) return t;
    return up ? (c + SLEW_N) : (c - SLEW_N);
  endfunction

  function automatic logic [CW-1:0] map_pos(input logic [IN_W-1:0] p);
    return CW'(64'(MIN_CYC) + ((64'(p) * SPAN) >> IN_W));
  endfunction

  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_next;
  logic                boundary;
  logic [CHANNELS-1:0] en_lat;
  logic [CHANNELS-1:0] en_next;
  logic [IN_W-1:0]     tgt_q      [CHANNELS];
  logic [IN_W-1:0]     cur_q      [CHANNELS];
  logic [IN_W-1:0]     cur_next   [CHANNELS];
  logic [CW-1:0]       width_q    [CHANNELS];
  logic [CW-1:0]       width_next [CHANNELS];

  always_comb begin
    boundary = (cnt == LAST);
    cnt_next = boundary ? '0 : (cnt + CW'(1));
    en_next  = boundary ? ch_enable : en_lat;
    for (int i = 0; i < CHANNELS; i++) begin
      cur_next[i]   = cur_q[i];
      width_next[i] = width_q[i];
      if (boundary && !hold) begin
        cur_next[i]   = slew_step(cur_q[i], tgt_q[i]);
        width_next[i] = map_pos(cur_next[i]);
      end
    end
  end

  // pwm looks one cycle ahead so its rise lines up with frame_start at cnt==0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      en_lat      <= '0;
      pwm         <= '0;
      frame_start <= 1'b0;
      settled     <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        tgt_q[i]   <= CENTRE;
        cur_q[i]   <= CENTRE;
        width_q[i] <= map_pos(CENTRE);
      end
    end else begin
      cnt         <= cnt_next;
      en_lat      <= en_next;
      frame_start <= boundary;
      for (int i = 0; i < CHANNELS; i++) begin
        cur_q[i]   <= cur_next[i];
        width_q[i] <= width_next[i];
        pwm[i]     <= en_next[i] && (cnt_next < width_next[i]);
        settled[i] <= (cur_q[i] == tgt_q[i]);
        if (target_valid && !hold)
          tgt_q[i] <= target[i*IN_W +: IN_W];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cur
    assign cur[g*IN_W +: IN_W] = cur_q[g];
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Self-checking bench for servo_pwm_array: a slew-limited and an unlimited instance
// share stimulus and are compared every cycle against a frame-level reference model.
module tb_servo_pwm_array;

  localparam int CH     = 2;
  localparam int IW     = 8;
  localparam int PERIOD = 100;
  localparam int MINC   = 10;
  localparam int MAXC   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        target_valid = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] target = '0;
  logic [1:0]  ch_enable = 2'b11;

  logic [1:0]  pwm_a, settled_a, pwm_b, settled_b;
  logic        fs_a, fs_b;
  logic [15:0] cur_a, cur_b;

  int checks = 0;
  int failures = 0;
  int hi_a0, hi_a1, hi_b0, fs_seen;

  int         m_pos;
  logic       m_fs;
  logic [1:0] m_en;
  int         m_tgt   [2][2];
  int         m_cur   [2][2];
  int         m_width [2][2];
  logic [1:0] m_pwm     [2];
  logic [1:0] m_settled [2];

  always #5 clk = ~clk;

  servo_pwm_array #(.CHANNELS(CH), .IN_W(IW), .PERIOD_CYC(PERIOD),
                    .MIN_CYC(MINC), .MAX_CYC(MAXC), .SLEW(16)) dut_a (
    .clk(clk), .rst(rst), .target(target), .target_valid(target_valid),
    .hold(hold), .ch_enable(ch_enable), .pwm(pwm_a), .frame_start(fs_a),
    .cur(cur_a), .settled(settled_a));

  servo_pwm_array #(.CHANNELS(CH), .IN_W(IW), .PERIOD_CYC(PERIOD),
                    .MIN_CYC(MINC), .MAX_CYC(MAXC), .SLEW(0)) dut_b (
    .clk(clk), .rst(rst), .target(target), .target_valid(target_valid),
    .hold(hold), .ch_enable(ch_enable), .pwm(pwm_b), .frame_start(fs_b),
    .cur(cur_b), .settled(settled_b));

  function automatic int m_map(input int p);
    return MINC + (p * (MAXC - MINC)) / (1 << IW);
  endfunction

  function automatic int m_slew(input int c, input int t, input int s);
    if (s == 0 || (t - c <= s && c - t <= s)) return t;
    if (t > c) return c + s;
    return c - s;
  endfunction

  // Instance 0 is slew-limited to 16 LSB per frame, instance 1 jumps straight to target.
  task automatic modelStep();
    logic bnd;
    if (rst) begin
      m_pos = 0;
      m_fs  = 1'b0;
      m_en  = 2'b00;
      for (int k = 0; k < 2; k++) begin
        m_pwm[k]     = 2'b00;
        m_settled[k] = 2'b11;
        for (int c = 0; c < CH; c++) begin
          m_tgt[k][c]   = 128;
          m_cur[k][c]   = 128;
          m_width[k][c] = m_map(128);
        end
      end
    end else begin
      bnd = (m_pos == PERIOD - 1);
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < CH; c++)
          m_settled[k][c] = (m_cur[k][c] == m_tgt[k][c]);
      if (bnd) begin
        m_en = ch_enable;
        if (!hold)
          for (int k = 0; k < 2; k++)
            for (int c = 0; c < CH; c++) begin
              m_cur[k][c]   = m_slew(m_cur[k][c], m_tgt[k][c], (k == 0) ? 16 : 0);
              m_width[k][c] = m_map(m_cur[k][c]);
            end
      end
      if (target_valid && !hold)
        for (int k = 0; k < 2; k++)
          for (int c = 0; c < CH; c++)
            m_tgt[k][c] = int'(target[c*IW +: IW]);
      m_pos = bnd ? 0 : m_pos + 1;
      m_fs  = bnd;
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < CH; c++)
          m_pwm[k][c] = m_en[c] && (m_pos < m_width[k][c]);
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("pwm_a", 32'(pwm_a), 32'(m_pwm[0]));
    checkVal("frame_start_a", 32'(fs_a), 32'(m_fs));
    checkVal("cur_a", 32'(cur_a), {16'd0, 8'(m_cur[0][1]), 8'(m_cur[0][0])});
    checkVal("settled_a", 32'(settled_a), 32'(m_settled[0]));
    checkVal("pwm_b", 32'(pwm_b), 32'(m_pwm[1]));
    checkVal("frame_start_b", 32'(fs_b), 32'(m_fs));
    checkVal("cur_b", 32'(cur_b), {16'd0, 8'(m_cur[1][1]), 8'(m_cur[1][0])});
    checkVal("settled_b", 32'(settled_b), 32'(m_settled[1]));
    hi_a0   += int'(pwm_a[0]);
    hi_a1   += int'(pwm_a[1]);
    hi_b0   += int'(pwm_b[0]);
    fs_seen += int'(fs_a);
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic tv, input logic [15:0] t, input logic h,
                               input logic [1:0] en);
    target_valid = tv;
    target       = t;
    hold         = h;
    ch_enable    = en;
    tick();
    target_valid = 1'b0;
  endtask

  task automatic clearCounters();
    hi_a0 = 0; hi_a1 = 0; hi_b0 = 0; fs_seen = 0;
  endtask

  // Leaves the bench at the negedge where cnt==PERIOD-1, just before a boundary edge.
  task automatic syncBoundary();
    int n;
    n = 0;
    while (m_pos != PERIOD - 1 && n < 2 * PERIOD) begin
      tick();
      n++;
    end
  endtask

  initial begin
    clearCounters();
    runCycles(3);
    checkVal("reset_pwm", 32'(pwm_a), 32'd0);
    checkVal("reset_cur", 32'(cur_a), 32'h8080);
    checkVal("reset_settled", 32'(settled_a), 32'd3);
    rst = 1'b0;

    $display("[TB] centre position, first frame silent");
    clearCounters();
    syncBoundary();
    checkVal("frame1_pwm_hi", 32'(hi_a0 + hi_a1), 32'd0);
    checkVal("frame1_fs", 32'(fs_seen), 32'd0);
    clearCounters();
    runCycles(PERIOD);
    checkVal("centre_w0", 32'(hi_a0), 32'd15);
    checkVal("centre_w1", 32'(hi_a1), 32'd15);
    checkVal("centre_fs", 32'(fs_seen), 32'd1);

    $display("[TB] full-scale slew");
    runCycles(20);
    applyStimulus(1'b1, {8'd255, 8'd0}, 1'b0, 2'b11);
    runCycles(9 * PERIOD);
    checkVal("slew_final_cur", 32'(cur_a), 32'hFF00);
    checkVal("slew_final_settled", 32'(settled_a), 32'd3);
    syncBoundary();
    clearCounters();
    runCycles(PERIOD);
    checkVal("slew_w0", 32'(hi_a0), 32'd10);
    checkVal("slew_w1", 32'(hi_a1), 32'd19);

    $display("[TB] disable channel 1 mid-pulse");
    clearCounters();
    runCycles(6);
    ch_enable = 2'b01;
    runCycles(PERIOD - 6);
    checkVal("disable_cur_frame_w1", 32'(hi_a1), 32'd19);
    clearCounters();
    runCycles(PERIOD);
    checkVal("disable_next_w1", 32'(hi_a1), 32'd0);
    checkVal("disable_next_w0", 32'(hi_a0), 32'd10);

    $display("[TB] hold behaviour");
    applyStimulus(1'b1, 16'h0000, 1'b1, 2'b11);
    runCycles(250);
    checkVal("hold_ignored_cur", 32'(cur_a), 32'hFF00);
    applyStimulus(1'b1, {8'd128, 8'd128}, 1'b0, 2'b11);
    syncBoundary();
    tick();
    syncBoundary();
    tick();
    hold = 1'b1;
    runCycles(250);
    checkVal("hold_frozen_cur", 32'(cur_a), {16'd0, 8'd223, 8'd32});
    checkVal("hold_frozen_settled", 32'(settled_a), 32'd0);
    hold = 1'b0;
    runCycles(9 * PERIOD);
    checkVal("hold_resume_cur", 32'(cur_a), 32'h8080);

    $display("[TB] unlimited slew instance");
    syncBoundary();
    runCycles(10);
    applyStimulus(1'b1, {8'd128, 8'd200}, 1'b0, 2'b11);
    syncBoundary();
    clearCounters();
    runCycles(2);
    checkVal("noslew_settled0", 32'(settled_b[0]), 32'd1);
    checkVal("noslew_cur0", 32'(cur_b[7:0]), 32'd200);
    runCycles(PERIOD - 2);
    checkVal("noslew_w0", 32'(hi_b0), 32'd17);

    $display("[TB] reset mid-pulse");
    runCycles(8);
    checkVal("pre_reset_pwm", 32'(pwm_a), 32'd3);
    rst = 1'b1;
    tick();
    checkVal("reset_pwm_drop_a", 32'(pwm_a), 32'd0);
    checkVal("reset_pwm_drop_b", 32'(pwm_b), 32'd0);
    tick();
    rst = 1'b0;
    clearCounters();
    syncBoundary();
    checkVal("post_reset_cur", 32'(cur_a), 32'h8080);
    checkVal("post_reset_silent", 32'(hi_a0 + hi_a1 + fs_seen), 32'd0);
    clearCounters();
    runCycles(PERIOD);
    checkVal("post_reset_w0", 32'(hi_a0), 32'd15);
    checkVal("post_reset_w1", 32'(hi_a1), 32'd15);

    $display("[TB] randomized traffic");
    for (int f = 0; f < 20; f++) begin
      hold      = ($urandom_range(0, 3) == 0);
      ch_enable = 2'($urandom_range(0, 3));
      for (int c = 0; c < PERIOD; c++) begin
        target_valid = ($urandom_range(0, 29) == 0);
        target       = 16'($urandom);
        tick();
      end
    end
    target_valid = 1'b0;
    hold = 1'b0;
    runCycles(PERIOD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
